// File: rtl/call_ret_unit_pkg.sv
// Shared opcode constants and FSM state encoding for the CALL/RET sequencer,
// the return stack and the instruction decoder.
package call_ret_unit_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_CALL   = 4'h1;
    localparam logic [3:0] OP_RET    = 4'h2;
    localparam logic [3:0] OP_PUSH_R = 4'h3;
    localparam logic [3:0] OP_POP_R  = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/call_ret_unit.sv
// CALL/RET sequencer: drives push/pop commands to the return stack and loads the PC.
// Optional overflow/underflow rejection with a sticky fault flag: CALLRET_FAULT_EN.
module call_ret_unit
    import call_ret_unit_pkg::*;
#(
    parameter  int DATA_W  = 14,
    parameter  int VOLUME  = 12,
    localparam int DEPTH_W = $clog2(VOLUME + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [3:0]         opcode,
    input  logic [DATA_W-1:0]  pc,
    input  logic [DATA_W-1:0]  target,
    input  logic [DATA_W-1:0]  stk_pop,
    output logic [3:0]         stk_op,
    output logic [DATA_W-1:0]  stk_push,
    output logic               pc_load,
    output logic [DATA_W-1:0]  pc_next,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               fault
);

    state_t             state, state_next;
    logic [DATA_W-1:0]  ret_q, tgt_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               call_req, ret_req;
    logic               overflow, underflow;

    assign call_req = valid && (opcode == OP_CALL);
    assign ret_req  = valid && (opcode == OP_RET);

`ifdef CALLRET_FAULT_EN
    logic fault_q;
    assign overflow  = call_req && (depth_q == DEPTH_W'(VOLUME));
    assign underflow = ret_req && (depth_q == '0);
    assign fault     = fault_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (call_req && !overflow)
                    state_next = ST_PUSH;
                else if (ret_req && !underflow)
                    state_next = ST_POP;
            end
            ST_PUSH: state_next = ST_IDLE;
            ST_POP:  state_next = ST_WAIT;
            ST_WAIT: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // WAIT forwards the stack's registered read data straight to the PC.
    always_comb begin
        stk_op   = OP_NOP;
        stk_push = '0;
        pc_load  = 1'b0;
        pc_next  = '0;
        case (state)
            ST_PUSH: begin
                stk_op   = OP_PUSH_R;
                stk_push = ret_q;
                pc_load  = 1'b1;
                pc_next  = tgt_q;
            end
            ST_POP: stk_op = OP_POP_R;
            ST_WAIT: begin
                pc_load = 1'b1;
                pc_next = stk_pop;
            end
            default: ;
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign depth = depth_q;

    // Depth wraps modulo VOLUME+1 so an unchecked build still stays in range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            ret_q   <= '0;
            tgt_q   <= '0;
            depth_q <= '0;
`ifdef CALLRET_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == ST_IDLE && state_next == ST_PUSH) begin
                ret_q <= pc + DATA_W'(1);
                tgt_q <= target;
            end
            if (state == ST_PUSH)
                depth_q <= (depth_q == DEPTH_W'(VOLUME)) ? '0 : depth_q + DEPTH_W'(1);
            else if (state == ST_POP)
                depth_q <= (depth_q == '0) ? DEPTH_W'(VOLUME) : depth_q - DEPTH_W'(1);
`ifdef CALLRET_FAULT_EN
            if (state == ST_IDLE && (overflow || underflow))
                fault_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_call_ret_unit.sv
// Bench for call_ret_unit: directed vector table, reset/limit sequences and
// randomized traffic against a queue-based model of the return stack.
module tb_call_ret_unit;
    import call_ret_unit_pkg::*;

    localparam int DATA_W  = 14;
    localparam int VOLUME  = 12;
    localparam int DEPTH_W = $clog2(VOLUME + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               valid;
    logic [3:0]         opcode;
    logic [DATA_W-1:0]  pc, target, stk_pop;
    logic [3:0]         stk_op;
    logic [DATA_W-1:0]  stk_push, pc_next;
    logic               pc_load, busy, fault;
    logic [DEPTH_W-1:0] depth;

    int checks   = 0;
    int failures = 0;

    call_ret_unit #(.DATA_W(DATA_W), .VOLUME(VOLUME)) dut (
        .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .pc(pc),
        .target(target), .stk_pop(stk_pop), .stk_op(stk_op), .stk_push(stk_push),
        .pc_load(pc_load), .pc_next(pc_next), .busy(busy), .depth(depth), .fault(fault)
    );

    always #5 clk = ~clk;

    // Environment return stack: registered read data, shares the reset.
    logic [DATA_W-1:0] mem [32];
    logic [4:0]        sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp      <= '0;
            stk_pop <= '0;
        end else if (stk_op == OP_PUSH_R) begin
            mem[sp] <= stk_push;
            sp      <= sp + 5'd1;
        end else if (stk_op == OP_POP_R) begin
            stk_pop <= mem[sp - 5'd1];
            sp      <= sp - 5'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0; opcode = OP_NOP; pc = '0; target = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic              valid;
        logic [3:0]        opcode;
        logic [DATA_W-1:0] pc, target;
        logic [3:0]        e_op;
        logic [DATA_W-1:0] e_push;
        logic              e_load;
        logic [DATA_W-1:0] e_next;
        logic              e_busy;
        int                e_depth;
    } vec_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] push;
        logic              load;
        logic [DATA_W-1:0] next;
        logic              busy;
        logic [DEPTH_W-1:0] dep;
    } exp_t;

    vec_t vecs [9];
    exp_t exp_q [$];
    logic [DATA_W-1:0] ret_list [$];
    int mdepth;
    logic mfault;

    initial begin
        // Expected outputs are those seen during the cycle the inputs are presented.
        vecs[0] = '{1, OP_CALL, 14'h0010, 14'h0200, OP_NOP,    14'h0000, 0, 14'h0000, 0, 0};
        vecs[1] = '{1, OP_RET,  14'h0020, 14'h0000, OP_PUSH_R, 14'h0011, 1, 14'h0200, 1, 0};
        vecs[2] = '{1, OP_RET,  14'h0200, 14'h0000, OP_NOP,    14'h0000, 0, 14'h0000, 0, 1};
        vecs[3] = '{1, OP_CALL, 14'h0100, 14'h0300, OP_POP_R,  14'h0000, 0, 14'h0000, 1, 1};
        vecs[4] = '{0, OP_NOP,  14'h0000, 14'h0000, OP_NOP,    14'h0000, 1, 14'h0011, 1, 0};
        vecs[5] = '{1, OP_CALL, 14'h3FFF, 14'h0005, OP_NOP,    14'h0000, 0, 14'h0000, 0, 0};
        vecs[6] = '{1, 4'hF,    14'h0001, 14'h0002, OP_PUSH_R, 14'h0000, 1, 14'h0005, 1, 0};
        vecs[7] = '{1, 4'hF,    14'h0001, 14'h0002, OP_NOP,    14'h0000, 0, 14'h0000, 0, 1};
        vecs[8] = '{0, OP_NOP,  14'h0000, 14'h0000, OP_NOP,    14'h0000, 0, 14'h0000, 0, 1};

        do_reset();
        @(negedge clk);
        chk("reset_stk_op", 32'(stk_op), 32'(OP_NOP));
        chk("reset_pc_load", 32'(pc_load), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_depth", 32'(depth), 0);
        chk("reset_fault", 32'(fault), 0);
        tick();

        for (int i = 0; i < 9; i++) begin
            valid = vecs[i].valid; opcode = vecs[i].opcode;
            pc = vecs[i].pc; target = vecs[i].target;
            @(negedge clk);
            chk($sformatf("vec%0d_stk_op", i),   32'(stk_op),   32'(vecs[i].e_op));
            chk($sformatf("vec%0d_stk_push", i), 32'(stk_push), 32'(vecs[i].e_push));
            chk($sformatf("vec%0d_pc_load", i),  32'(pc_load),  32'(vecs[i].e_load));
            chk($sformatf("vec%0d_pc_next", i),  32'(pc_next),  32'(vecs[i].e_next));
            chk($sformatf("vec%0d_busy", i),     32'(busy),     32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_depth", i),    32'(depth),    32'(vecs[i].e_depth));
            chk($sformatf("vec%0d_fault", i),    32'(fault),    0);
            tick();
        end

        // Reset asserted during the WAIT cycle of a RET.
        valid = 1'b1; opcode = OP_RET;
        tick();
        valid = 1'b0;
        tick();
        chk("wait_pc_load_before_reset", 32'(pc_load), 1);
        reset = 1'b1;
        #1;
        chk("abort_pc_load", 32'(pc_load), 0);
        chk("abort_stk_op", 32'(stk_op), 32'(OP_NOP));
        chk("abort_depth", 32'(depth), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pc_next", 32'(pc_next), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("after_abort_pc_load", 32'(pc_load), 0);
        tick();

        // Twelve CALLs fill the stack, then a thirteenth probes the limit.
        do_reset();
        for (int i = 0; i < VOLUME; i++) begin
            valid = 1'b1; opcode = OP_CALL; pc = 14'(i * 16); target = 14'(i);
            tick();
            valid = 1'b0;
            tick();
        end
        chk("full_depth", 32'(depth), VOLUME);
        valid = 1'b1; opcode = OP_CALL; pc = 14'h0123; target = 14'h0456;
        tick();
        valid = 1'b0;
        @(negedge clk);
`ifdef CALLRET_FAULT_EN
        chk("ovf_stk_op", 32'(stk_op), 32'(OP_NOP));
        chk("ovf_pc_load", 32'(pc_load), 0);
        chk("ovf_busy", 32'(busy), 0);
        chk("ovf_fault", 32'(fault), 1);
        tick();
        chk("ovf_depth", 32'(depth), VOLUME);
        chk("ovf_fault_sticky", 32'(fault), 1);
`else
        chk("wrap_stk_op", 32'(stk_op), 32'(OP_PUSH_R));
        chk("wrap_fault", 32'(fault), 0);
        tick();
        chk("wrap_depth", 32'(depth), 0);
`endif

        // RET straight after reset, at depth 0.
        do_reset();
        valid = 1'b1; opcode = OP_RET;
        tick();
        valid = 1'b0;
        @(negedge clk);
`ifdef CALLRET_FAULT_EN
        chk("udf_stk_op", 32'(stk_op), 32'(OP_NOP));
        chk("udf_busy", 32'(busy), 0);
        chk("udf_fault", 32'(fault), 1);
        chk("udf_depth", 32'(depth), 0);
`else
        chk("udf_stk_op", 32'(stk_op), 32'(OP_POP_R));
        chk("udf_fault", 32'(fault), 0);
`endif
        tick();

        // Randomized traffic against the queue model.
        do_reset();
        exp_q.delete(); ret_list.delete(); mdepth = 0; mfault = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_t e;
            int r;
            logic idle;
            valid  = ($urandom_range(0, 3) != 0);
            r      = $urandom_range(0, 9);
            opcode = (r < 4) ? OP_CALL : (r < 8) ? OP_RET : 4'($urandom_range(5, 15));
            if (opcode == OP_CALL && mdepth == VOLUME) opcode = 4'h7;
            if (opcode == OP_RET && mdepth == 0) opcode = 4'h8;
            pc     = 14'($urandom_range(0, 16383));
            target = 14'($urandom_range(0, 16383));
            @(negedge clk);
            idle = (exp_q.size() == 0);
            e = idle ? exp_t'{OP_NOP, 14'h0, 1'b0, 14'h0, 1'b0, DEPTH_W'(mdepth)}
                     : exp_q.pop_front();
            chk("rnd_stk_op", 32'(stk_op), 32'(e.op));
            chk("rnd_stk_push", 32'(stk_push), 32'(e.push));
            chk("rnd_pc_load", 32'(pc_load), 32'(e.load));
            chk("rnd_pc_next", 32'(pc_next), 32'(e.next));
            chk("rnd_busy", 32'(busy), 32'(e.busy));
            chk("rnd_depth", 32'(depth), 32'(e.dep));
            chk("rnd_fault", 32'(fault), 32'(mfault));
            if (idle && valid && opcode == OP_CALL) begin
                logic [DATA_W-1:0] ret;
                ret = 14'((int'(pc) + 1) % 16384);
                exp_q.push_back(exp_t'{OP_PUSH_R, ret, 1'b1, target, 1'b1, DEPTH_W'(mdepth)});
                ret_list.push_back(ret);
                mdepth++;
            end else if (idle && valid && opcode == OP_RET) begin
                exp_q.push_back(exp_t'{OP_POP_R, 14'h0, 1'b0, 14'h0, 1'b1, DEPTH_W'(mdepth)});
                exp_q.push_back(exp_t'{OP_NOP, 14'h0, 1'b1, ret_list.pop_back(), 1'b1,
                                       DEPTH_W'(mdepth - 1)});
                mdepth--;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_ret_unit.md
# call_ret_unit

Sequencer for CALL/RET instructions that drives the CPU's 12-entry return stack. Decodes CALL/RET issue from the control path and issues OP_PUSH_R / OP_POP_R commands to the stack. Collects popped return addresses and hands the program counter its next value. Sits between instruction decode and the stack; the PC register consumes its pc_load/pc_next outputs.

## Interface
- DATA_W, 14: address/data width; matches the stack word width.
- VOLUME, 12: stack depth in entries; limit for overflow checks.

- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- valid  in  1  an instruction is issued this cycle.
- opcode  in  4  opcode of the issued instruction; only OP_CALL and OP_RET are acted on.
- pc  in  DATA_W  address of the issued instruction.
- target  in  DATA_W  CALL destination address.
- stk_pop  in  DATA_W  stack read data; valid the cycle after stk_op = OP_POP_R.
- stk_op  out  4  command to the stack: OP_PUSH_R, OP_POP_R or OP_NOP.
- stk_push  out  DATA_W  data to push; meaningful only while stk_op = OP_PUSH_R.
- pc_load  out  1  one-cycle strobe; PC takes pc_next.
- pc_next  out  DATA_W  new PC value.
- busy  out  1  high in every non-IDLE state; issuer must stall while high.
- depth  out  $clog2(VOLUME+1)  current number of stacked return addresses.
- fault  out  1  sticky overflow/underflow flag.

## Operation
- The FSM has four states: IDLE, PUSH, POP, WAIT.
- **IDLE**
  - valid with OP_CALL goes to PUSH, latching ret = pc+1 (mod 2^DATA_W) and target.
  - valid with OP_RET goes to POP.
  - Any other opcode, or valid low, stays in IDLE.
- **PUSH** (one cycle), then IDLE.
  - stk_op = OP_PUSH_R, stk_push = ret.
  - pc_load = 1, pc_next = target.
  - depth increments.
- **POP** (one cycle), then WAIT.
  - stk_op = OP_POP_R.
  - depth decrements.
- **WAIT** (one cycle), then IDLE.
  - stk_op = OP_NOP.
  - pc_load = 1, pc_next = stk_pop, passed through combinationally from the stack's registered output.
- Outside PUSH and WAIT: pc_load = 0, stk_op = OP_NOP, pc_next and stk_push = 0.
- valid while busy is ignored and not queued. At most one stack command is issued per request.
- Reset values:
  - state IDLE, depth 0, fault 0, busy 0, pc_load 0.
  - stk_op = OP_NOP; stk_push and pc_next = 0.
  - Reset mid-sequence aborts the sequence; no partial pc_load follows.
  - The stack shares the same reset, so the pointers stay consistent.

## Timing
- CALL accepted at edge N: PUSH during cycle N+1, with pc_load and stk_op = OP_PUSH_R asserted together. Back in IDLE at edge N+2.
- RET accepted at edge N: OP_POP_R during cycle N+1; pc_load during cycle N+2 with the popped data. Back in IDLE at edge N+3.
- Throughput:
  - one CALL every 2 cycles;
  - one RET every 3 cycles.
- busy rises on the accepting edge and falls on the edge that returns the FSM to IDLE. The issuer may present the next request in the first IDLE cycle.

## Configuration
- CALLRET_FAULT_EN defined:
  - CALL with depth == VOLUME is rejected (overflow). RET with depth == 0 is rejected (underflow).
  - A rejected request leaves the FSM in IDLE and issues no stack op and no pc_load.
  - fault rises at the next edge and holds until reset.
- CALLRET_FAULT_EN undefined:
  - No checks are made; fault is tied to 0.
  - depth wraps modulo VOLUME+1. The stack pointer wrap behaviour is then the software's responsibility.

## Structure
- Shared defines/package holds:
  - OP_CALL, OP_RET, OP_PUSH_R, OP_POP_R, OP_NOP opcode constants, all 4-bit;
  - the state encoding (2-bit).
  - The stack and decoder include the same file.
- No sub-module. Single always block for state, depth and latched ret/target; combinational output decode.

## Test plan
- Reset, then CALL with pc=0x0010, target=0x0200:
  - cycle+1: stk_op = OP_PUSH_R, stk_push = 0x0011, pc_load = 1, pc_next = 0x0200;
  - depth = 1, busy low 2 cycles after accept.
- CALL pc=0x0010, then RET with the stack model returning 0x0011:
  - OP_POP_R one cycle after accept;
  - pc_load = 1 with pc_next = 0x0011 two cycles after accept;
  - depth back to 0.
- CALL issued while busy during a RET sequence: dropped, no second stack op, depth unchanged.
- pc=0x3FFF with DATA_W=14: stk_push = 0x0000 (wrap).
- With CALLRET_FAULT_EN:
  - 12 CALLs then a 13th: no OP_PUSH_R and no pc_load, fault = 1, depth = 12.
  - After reset, RET at depth 0: fault = 1, no OP_POP_R.
- Assert reset during the WAIT cycle of a RET: pc_load drops immediately, state IDLE, depth = 0, stk_op = OP_NOP.
